// File: rtl/fpu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fpu_issue_ctrl
//
// Decode, floating-point register file and issue sequencer in front of the FPU
// arithmetic unit. The instruction bus is free-running, with no valid strobe.
// A word is taken in IDLE when it is nonzero and differs from the last word
// taken.
//   - LUI (opcode 001111) writes {imm, 16'h0} into reg[rt] on the accepting edge.
//   - COP1 (opcode 010001) add/sub/mul/div, single or double precision, issues
//     one operation, waits for op_done (bounded by TIMEOUT) and writes back.
//   - Any other word sets the sticky wrong flag.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   instruction  32-bit instruction bus
//   op_start     one-cycle issue pulse to the arithmetic unit
//   op_code      00 add, 01 sub, 10 mul, 11 div
//   op_dbl       1 = double precision, 0 = single precision
//   op_a, op_b   operands fs / ft (single precision: zero-extended [31:0])
//   op_done      result-valid pulse from the unit (used only while waiting)
//   res          result (single precision uses [31:0])
//   res_wrong    exception flag from the unit, sampled with op_done
//   out_32       last single-precision result
//   out_64       last double-precision result
//   complete     one-cycle pulse while writeback happens
//   wrong        error flag, sticky until the next accepted instruction
// -----------------------------------------------------------------------------
module fpu_issue_ctrl #(
  parameter int unsigned TIMEOUT = 64  // legal range 2..255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  output logic        op_start,
  output logic [1:0]  op_code,
  output logic        op_dbl,
  output logic [63:0] op_a,
  output logic [63:0] op_b,
  input  logic        op_done,
  input  logic [63:0] res,
  input  logic        res_wrong,
  output logic [31:0] out_32,
  output logic [63:0] out_64,
  output logic        complete,
  output logic        wrong
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WB
  } state_e;

  localparam logic [5:0] OPC_LUI  = 6'b001111;
  localparam logic [5:0] OPC_COP1 = 6'b010001;
  localparam logic [4:0] FMT_S    = 5'b10000;
  localparam logic [4:0] FMT_D    = 5'b00001;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  logic [31:0] last_instr_q, last_instr_d;
  logic [1:0]  op_code_q, op_code_d;
  logic        op_dbl_q, op_dbl_d;
  logic [63:0] op_a_q, op_a_d;
  logic [63:0] op_b_q, op_b_d;
  logic [4:0]  fd_q, fd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic        res_wrong_q, res_wrong_d;
  logic [31:0] out_32_q, out_32_d;
  logic [63:0] out_64_q, out_64_d;
  logic        wrong_q, wrong_d;

  // ---------------------------------------------------------------------------
  // Instruction field decode
  // ---------------------------------------------------------------------------
  logic [5:0]  f_opcode;
  logic [4:0]  f_fmt;
  logic [4:0]  f_ft;
  logic [4:0]  f_fs;
  logic [4:0]  f_fd;
  logic [5:0]  f_funct;
  logic [15:0] f_imm;
  logic [4:0]  fs_nxt;
  logic [4:0]  ft_nxt;
  logic [4:0]  fd_nxt;
  logic        is_lui;
  logic        is_cop1_ok;
  logic        fmt_dbl;
  logic        accept;

  assign f_opcode = instruction[31:26];
  assign f_fmt    = instruction[25:21];
  assign f_ft     = instruction[20:16];  // doubles as rt for LUI
  assign f_fs     = instruction[15:11];
  assign f_fd     = instruction[10:6];
  assign f_funct  = instruction[5:0];
  assign f_imm    = instruction[15:0];

  // Register pairs wrap from 31 to 0; 5-bit addition gives the modulo for free.
  assign fs_nxt   = f_fs + 5'd1;
  assign ft_nxt   = f_ft + 5'd1;
  assign fd_nxt   = fd_q + 5'd1;

  assign fmt_dbl    = (f_fmt == FMT_D);
  assign is_lui     = (f_opcode == OPC_LUI);
  assign is_cop1_ok = (f_opcode == OPC_COP1) &&
                      ((f_fmt == FMT_S) || (f_fmt == FMT_D)) &&
                      (f_funct[5:2] == 4'b0000);

  // The bus has no strobe: a new word is recognised by being different from
  // the last one taken. Zero is a NOP and never taken.
  assign accept = (state_q == S_IDLE) &&
                  (instruction != 32'h0) &&
                  (instruction != last_instr_q);

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    rf_d         = rf_q;
    last_instr_d = last_instr_q;
    op_code_d    = op_code_q;
    op_dbl_d     = op_dbl_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    fd_d         = fd_q;
    cnt_d        = cnt_q;
    res_d        = res_q;
    res_wrong_d  = res_wrong_q;
    out_32_d     = out_32_q;
    out_64_d     = out_64_q;
    wrong_d      = wrong_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          last_instr_d = instruction;
          wrong_d      = 1'b0;
          if (is_lui) begin
            rf_d[f_ft] = {f_imm, 16'h0000};
          end else if (is_cop1_ok) begin
            // Operands come straight from the array on the accepting edge, so
            // any earlier LUI is already visible.
            op_code_d = f_funct[1:0];
            op_dbl_d  = fmt_dbl;
            op_a_d    = fmt_dbl ? {rf_q[f_fs], rf_q[fs_nxt]} : {32'h0, rf_q[f_fs]};
            op_b_d    = fmt_dbl ? {rf_q[f_ft], rf_q[ft_nxt]} : {32'h0, rf_q[f_ft]};
            fd_d      = f_fd;
            state_d   = S_ISSUE;
          end else begin
            wrong_d = 1'b1;
          end
        end
      end

      S_ISSUE: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (op_done) begin
          res_d       = res;
          res_wrong_d = res_wrong;
          state_d     = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          // Unit never answered: abandon the operation without writeback.
          wrong_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_WB: begin
        if (op_dbl_q) begin
          rf_d[fd_q]   = res_q[63:32];
          rf_d[fd_nxt] = res_q[31:0];
          out_64_d     = res_q;
        end else begin
          rf_d[fd_q]   = res_q[31:0];
          out_32_d     = res_q[31:0];
        end
        wrong_d = res_wrong_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // reg0 is hard-wired to zero; this overrides any write aimed at it.
    rf_d[0] = 32'h0;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the register file is reset on purpose: an abort by reset must
      // leave every register reading zero, so it is built from flops rather
      // than a RAM macro.
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
      last_instr_q <= 32'h0;
      op_code_q    <= 2'b00;
      op_dbl_q     <= 1'b0;
      op_a_q       <= 64'h0;
      op_b_q       <= 64'h0;
      fd_q         <= 5'd0;
      cnt_q        <= 8'd0;
      res_q        <= 64'h0;
      res_wrong_q  <= 1'b0;
      out_32_q     <= 32'h0;
      out_64_q     <= 64'h0;
      wrong_q      <= 1'b0;
    end else begin
      rf_q         <= rf_d;
      last_instr_q <= last_instr_d;
      op_code_q    <= op_code_d;
      op_dbl_q     <= op_dbl_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      fd_q         <= fd_d;
      cnt_q        <= cnt_d;
      res_q        <= res_d;
      res_wrong_q  <= res_wrong_d;
      out_32_q     <= out_32_d;
      out_64_q     <= out_64_d;
      wrong_q      <= wrong_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: pulses decode directly from the registered state.
  // ---------------------------------------------------------------------------
  assign op_start = (state_q == S_ISSUE);
  assign complete = (state_q == S_WB);
  assign op_code  = op_code_q;
  assign op_dbl   = op_dbl_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign out_32   = out_32_q;
  assign out_64   = out_64_q;
  assign wrong    = wrong_q;

endmodule

// File: doc/fpu_issue_ctrl.md
Name: fpu_issue_ctrl

Overview:
Instruction decode, FP register file and issue sequencer that sits directly upstream of the FPU arithmetic unit inside top. It watches the free-running 32-bit instruction bus and executes LUI immediately into a 32x32 register file. For COP1 arithmetic it reads operands, issues one operation to the arithmetic unit and waits for its result. It then writes the result back and drives out_32/out_64/complete/wrong.

Parameters:
TIMEOUT, 64, maximum cycles to wait for op_done before aborting (range 2..255).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
instruction  in  32  instruction bus; no valid strobe.
op_start  out  1  one-cycle issue pulse to the arithmetic unit.
op_code  out  2  00 add, 01 sub, 10 mul, 11 div.
op_dbl  out  1  1 = double precision, 0 = single precision.
op_a  out  64  operand fs; single precision uses [31:0] with [63:32] = 0.
op_b  out  64  operand ft; same format rule as op_a.
op_done  in  1  result-valid pulse from the arithmetic unit.
res  in  64  result; single precision uses [31:0].
res_wrong  in  1  exception flag from the unit, sampled with op_done.
out_32  out  32  last single-precision result.
out_64  out  64  last double-precision result.
complete  out  1  one-cycle pulse when writeback happens.
wrong  out  1  error flag; sticky until the next accepted instruction.

Behaviour:
- Reset (rst=0, async): all registers, last_instr, op_*, out_32, out_64, complete, wrong = 0; state = IDLE.
- Acceptance: in IDLE, instruction is accepted at a clock edge when it is nonzero and differs from last_instr.
  - On acceptance, last_instr <= instruction and wrong <= 0.
  - The value 0 is a NOP and is never accepted.
  - Instruction changes outside IDLE are ignored. After returning to IDLE, the instruction bus is compared again, so a change made while busy is picked up then.
- LUI (opcode [31:26]=001111):
  - reg[rt] <= {imm[15:0], 16'h0}, where rt=[20:16].
  - Written on the accepting edge; stays in IDLE; no complete pulse.
  - rt=0 is discarded (reg0 reads 0).
- COP1 (opcode 010001): fmt=[25:21], ft=[20:16], fs=[15:11], fd=[10:6], funct=[5:0].
  - fmt 10000 = single; fmt 00001 = double.
  - funct 000000..000011 map to op_code 00..11.
- Double operand for register r: {reg[r], reg[(r+1) mod 32]}.
- Illegal instruction: any other opcode, fmt or funct (funct > 3).
  - On the accepting edge, wrong <= 1; stays in IDLE; no complete pulse.
- FSM: IDLE -> ISSUE -> WAIT -> WB -> IDLE.
  - IDLE: on accepting a legal COP1, latch op_code, op_dbl, op_a, op_b and fd; go to ISSUE.
  - ISSUE: op_start=1 for exactly this cycle; clear the timeout counter; go to WAIT.
  - WAIT: on op_done=1, capture res and res_wrong and go to WB. Otherwise increment the counter. When the counter reaches TIMEOUT-1 with no op_done: wrong <= 1, go to IDLE, no writeback, no complete pulse.
  - WB, single: reg[fd] <= res[31:0]; out_32 <= res[31:0].
  - WB, double: reg[fd] <= res[63:32]; reg[(fd+1) mod 32] <= res[31:0]; out_64 <= res.
  - WB, both widths: complete=1 for one cycle; wrong <= captured res_wrong; go to IDLE.
  - Writes to reg0 are discarded in all cases.
- op_done in any state other than WAIT is ignored.
- Operands are read on the accepting edge, so a LUI accepted earlier is always visible to a later COP1.
- Latency: accept edge -> op_start high in the next cycle. op_done edge -> complete high in the next cycle. Minimum COP1 occupancy is 4 cycles.
- Reset asserted mid-operation aborts immediately with no writeback; after release, the instruction currently on the bus is accepted if it is nonzero.

Test Plan:
- LUI reg1<-0xC000, then reg2<-0x4000, then single mul (fs=2, ft=1, fd=9) -> op_start one cycle later with op_a=0x0000_0000_4000_0000, op_b=0x0000_0000_C000_0000, op_code=10, op_dbl=0.
- Model returns res=0xC080_0000 after 5 cycles -> complete pulse next cycle; out_32=0xC0800000; reg9 holds it (verify by issuing an op with fs=9); wrong=0.
- LUI reg5=0xD254_0000 and reg6=0x52C4_0000; double mul with ft=5, fs=7, fd=11 -> op_b=0xD2540000_52C40000. res=0x1122334455667788 -> reg11=0x11223344, reg12=0x55667788, out_64 matches.
- Hold the same COP1 word on the bus for 100 cycles -> exactly one op_start. Change the instruction while in WAIT -> it is accepted only after WB.
- Model never asserts op_done, TIMEOUT=64 -> wrong=1 and return to IDLE; no complete pulse. The next accepted LUI clears wrong.
- Illegal funct 000111 -> wrong=1, no op_start. Pulse rst low during WAIT -> all outputs 0 and no writeback.
